router_sync_n: RTL and testbench



---
 rtl/router_sync_n.sv | 105 ++++++++++
 tb/tb_router_sync_n.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_sync_n.sv
// router_sync_n: latches the packet destination, decodes FIFO write enables and full flag,
// and runs a per-channel read-timeout watchdog that soft-resets stalled output FIFOs.
module router_sync_n #(
   parameter int NUM_CH  = 3,
   parameter int ADDR_W  = 2,
   parameter int TIMEOUT = 30,
   parameter int CNT_W   = 8
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              detect_add,
   input  logic [ADDR_W-1:0] data_in,
   input  logic              write_enb_reg,
   input  logic [NUM_CH-1:0] read_enb,
   input  logic [NUM_CH-1:0] empty,
   input  logic [NUM_CH-1:0] full,
   input  logic              clr_status,
   output logic [NUM_CH-1:0] write_enb,
   output logic              fifo_full,
   output logic              addr_err,
   output logic [NUM_CH-1:0] vld_out,
   output logic [NUM_CH-1:0] soft_reset,
   output logic [NUM_CH-1:0] timeout_flag
);

   localparam logic [ADDR_W:0]   NUM_CH_L = (ADDR_W+1)'(NUM_CH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] ADDR_RST = {ADDR_W{1'b1}};

   logic [ADDR_W-1:0] int_addr_r;
   logic              addr_ok_s;
   logic [CNT_W-1:0]  cnt_r [NUM_CH];
   logic [NUM_CH-1:0] stall_s;
   logic [NUM_CH-1:0] expire_s;

   // Destination address latch, loaded on the header strobe
   always_ff @(posedge clock) begin
      if (!resetn) begin
         int_addr_r <= ADDR_RST;
      end else if (detect_add) begin
         int_addr_r <= data_in;
      end else begin
         int_addr_r <= int_addr_r;
      end
   end

   assign addr_ok_s = ({1'b0, int_addr_r} < NUM_CH_L);
   assign addr_err  = ~addr_ok_s;
   assign vld_out   = ~empty;

   // One-hot write enable and full-flag mux for the latched address
   always_comb begin
      write_enb = {NUM_CH{1'b0}};
      fifo_full = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (resetn && addr_ok_s && (int_addr_r == ADDR_W'(i))) begin
            write_enb[i] = write_enb_reg;
            fifo_full    = full[i];
         end else begin
            write_enb[i] = 1'b0;
         end
      end
   end

   // Per-channel stall detection and expiry of the watchdog count
   always_comb begin
      stall_s  = {NUM_CH{1'b0}};
      expire_s = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         stall_s[i]  = vld_out[i] & ~read_enb[i];
         expire_s[i] = stall_s[i] & (cnt_r[i] == CNT_LAST);
      end
   end

   // Watchdog counters and registered one-cycle soft-reset pulses
   always_ff @(posedge clock) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_r[i] <= {CNT_W{1'b0}};
         end
         soft_reset <= {NUM_CH{1'b0}};
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (expire_s[i] || !stall_s[i]) begin
               cnt_r[i] <= {CNT_W{1'b0}};
            end else begin
               cnt_r[i] <= cnt_r[i] + CNT_W'(1);
            end
         end
         soft_reset <= expire_s;
      end
   end

   // Sticky timeout status; a fresh expiry outranks a simultaneous clear
   always_ff @(posedge clock) begin
      if (!resetn) begin
         timeout_flag <= {NUM_CH{1'b0}};
      end else if (clr_status) begin
         timeout_flag <= expire_s;
      end else begin
         timeout_flag <= timeout_flag | expire_s;
      end
   end

endmodule

// File: tb/tb_router_sync_n.sv
// Self-checking bench for router_sync_n: directed scenarios plus randomized traffic on two
// configurations (3 ch / timeout 30 and 5 ch / timeout 4) against a run-length reference model.
module tb_router_sync_n;

   localparam int TO_A = 30;
   localparam int TO_B = 4;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic resetn;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic       a_detect_add, a_write_enb_reg, a_clr_status;
   logic [1:0] a_data_in;
   logic [2:0] a_read_enb, a_empty, a_full;
   logic [2:0] a_write_enb, a_vld_out, a_soft_reset, a_timeout_flag;
   logic       a_fifo_full, a_addr_err;

   logic       b_detect_add, b_write_enb_reg, b_clr_status;
   logic [2:0] b_data_in;
   logic [4:0] b_read_enb, b_empty, b_full;
   logic [4:0] b_write_enb, b_vld_out, b_soft_reset, b_timeout_flag;
   logic       b_fifo_full, b_addr_err;

   router_sync_n dut_a (
      .clock(clock), .resetn(resetn), .detect_add(a_detect_add), .data_in(a_data_in),
      .write_enb_reg(a_write_enb_reg), .read_enb(a_read_enb), .empty(a_empty), .full(a_full),
      .clr_status(a_clr_status), .write_enb(a_write_enb), .fifo_full(a_fifo_full),
      .addr_err(a_addr_err), .vld_out(a_vld_out), .soft_reset(a_soft_reset),
      .timeout_flag(a_timeout_flag));

   router_sync_n #(.NUM_CH(5), .ADDR_W(3), .TIMEOUT(TO_B), .CNT_W(8)) dut_b (
      .clock(clock), .resetn(resetn), .detect_add(b_detect_add), .data_in(b_data_in),
      .write_enb_reg(b_write_enb_reg), .read_enb(b_read_enb), .empty(b_empty), .full(b_full),
      .clr_status(b_clr_status), .write_enb(b_write_enb), .fifo_full(b_fifo_full),
      .addr_err(b_addr_err), .vld_out(b_vld_out), .soft_reset(b_soft_reset),
      .timeout_flag(b_timeout_flag));

   // Reference model: a channel pulses whenever its unbroken stall run reaches a multiple of TIMEOUT
   int         ma_addr, mb_addr;
   int         ma_run [3];
   int         mb_run [5];
   logic [2:0] ma_pulse, ma_flag;
   logic [4:0] mb_pulse, mb_flag;

   function automatic logic [7:0] exp_we(input logic rst_ok, input logic wreg, input int addr, input int nch);
      logic [7:0] v;
      v = 8'h00;
      if (rst_ok && wreg && addr < nch) v[addr] = 1'b1;
      return v;
   endfunction

   function automatic logic exp_ff(input logic rst_ok, input logic [7:0] f, input int addr, input int nch);
      return (rst_ok && addr < nch) ? f[addr] : 1'b0;
   endfunction

   task automatic tick();
      if (!resetn) begin
         ma_addr = 3; mb_addr = 7;
         ma_pulse = 3'b000; ma_flag = 3'b000; mb_pulse = 5'b00000; mb_flag = 5'b00000;
         for (int c = 0; c < 3; c++) ma_run[c] = 0;
         for (int c = 0; c < 5; c++) mb_run[c] = 0;
      end else begin
         for (int c = 0; c < 3; c++) begin
            if (!a_empty[c] && !a_read_enb[c]) begin
               ma_run[c]++;
               ma_pulse[c] = ((ma_run[c] % TO_A) == 0);
            end else begin
               ma_run[c] = 0;
               ma_pulse[c] = 1'b0;
            end
         end
         for (int c = 0; c < 5; c++) begin
            if (!b_empty[c] && !b_read_enb[c]) begin
               mb_run[c]++;
               mb_pulse[c] = ((mb_run[c] % TO_B) == 0);
            end else begin
               mb_run[c] = 0;
               mb_pulse[c] = 1'b0;
            end
         end
         ma_flag = (a_clr_status ? 3'b000 : ma_flag) | ma_pulse;
         mb_flag = (b_clr_status ? 5'b00000 : mb_flag) | mb_pulse;
         if (a_detect_add) ma_addr = int'(a_data_in);
         if (b_detect_add) mb_addr = int'(b_data_in);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      a_detect_add = 1'b1; a_data_in = 2'd0; a_write_enb_reg = 1'b1; a_full = 3'b111;
      a_empty = 3'b000; a_read_enb = 3'b000; a_clr_status = 1'b0;
      b_detect_add = 1'b0; b_data_in = 3'd0; b_write_enb_reg = 1'b0; b_full = 5'b00000;
      b_empty = 5'b11111; b_read_enb = 5'b00000; b_clr_status = 1'b0;
      tick(); tick();
      n_checks++; if (a_write_enb !== 3'b000) begin n_fail++; $display("FAIL rst_we: got %b expected 000", a_write_enb); end
      n_checks++; if (a_fifo_full !== 1'b0) begin n_fail++; $display("FAIL rst_ff: got %b expected 0", a_fifo_full); end
      n_checks++; if (a_addr_err !== 1'b1) begin n_fail++; $display("FAIL rst_err: got %b expected 1", a_addr_err); end
      n_checks++; if (a_vld_out !== 3'b111) begin n_fail++; $display("FAIL rst_vld: got %b expected 111", a_vld_out); end
      n_checks++; if (a_soft_reset !== 3'b000) begin n_fail++; $display("FAIL rst_sr: got %b expected 000", a_soft_reset); end
      n_checks++; if (a_timeout_flag !== 3'b000) begin n_fail++; $display("FAIL rst_flag: got %b expected 000", a_timeout_flag); end
      n_checks++; if (b_addr_err !== 1'b1) begin n_fail++; $display("FAIL rst_err_b: got %b expected 1", b_addr_err); end
      resetn = 1'b1; a_detect_add = 1'b0; a_empty = 3'b111;
      tick();
      n_checks++; if (a_addr_err !== 1'b1 || a_write_enb !== 3'b000) begin
         n_fail++; $display("FAIL post_rst_addr: got err=%b we=%b expected err=1 we=000", a_addr_err, a_write_enb); end
   endtask

   task automatic test_addr_decode();
      a_full = 3'b010; a_detect_add = 1'b1; a_data_in = 2'd1; a_write_enb_reg = 1'b1;
      #1;
      n_checks++; if (a_write_enb !== 3'b000) begin n_fail++; $display("FAIL we_old_invalid: got %b expected 000", a_write_enb); end
      tick(); a_detect_add = 1'b0;
      n_checks++; if (a_write_enb !== 3'b010) begin n_fail++; $display("FAIL we_addr1: got %b expected 010", a_write_enb); end
      n_checks++; if (a_fifo_full !== 1'b1 || a_addr_err !== 1'b0) begin
         n_fail++; $display("FAIL ff_addr1: got ff=%b err=%b expected ff=1 err=0", a_fifo_full, a_addr_err); end
      a_full = 3'b101; #1;
      n_checks++; if (a_fifo_full !== 1'b0) begin n_fail++; $display("FAIL ff_track: got %b expected 0", a_fifo_full); end
      a_write_enb_reg = 1'b0; #1;
      n_checks++; if (a_write_enb !== 3'b000) begin n_fail++; $display("FAIL we_noreq: got %b expected 000", a_write_enb); end
      a_write_enb_reg = 1'b1; a_detect_add = 1'b1; a_data_in = 2'd2; #1;
      n_checks++; if (a_write_enb !== 3'b010) begin n_fail++; $display("FAIL we_same_cycle: got %b expected 010", a_write_enb); end
      tick(); a_detect_add = 1'b0;
      n_checks++; if (a_write_enb !== 3'b100 || a_fifo_full !== 1'b1) begin
         n_fail++; $display("FAIL we_addr2: got we=%b ff=%b expected we=100 ff=1", a_write_enb, a_fifo_full); end
      a_detect_add = 1'b1; a_data_in = 2'd3;
      tick(); a_detect_add = 1'b0; a_full = 3'b111; #1;
      n_checks++; if (a_addr_err !== 1'b1 || a_write_enb !== 3'b000 || a_fifo_full !== 1'b0) begin
         n_fail++; $display("FAIL addr3: got err=%b we=%b ff=%b expected err=1 we=000 ff=0", a_addr_err, a_write_enb, a_fifo_full); end
      a_detect_add = 1'b1; a_data_in = 2'd0;
      tick(); a_detect_add = 1'b0;
   endtask

   task automatic test_timeout_periodic();
      logic e;
      a_empty = 3'b111; a_read_enb = 3'b000; a_clr_status = 1'b1;
      tick(); a_clr_status = 1'b0;
      a_empty = 3'b110;
      for (int k = 1; k <= 65; k++) begin
         tick();
         e = (k == 30 || k == 60);
         n_checks++; if (a_soft_reset[0] !== e) begin n_fail++; $display("FAIL periodic k=%0d: got %b expected %b", k, a_soft_reset[0], e); end
         if (k == 30) begin
            n_checks++; if (a_timeout_flag !== 3'b001) begin n_fail++; $display("FAIL periodic_flag: got %b expected 001", a_timeout_flag); end
         end
      end
      a_empty = 3'b111; a_clr_status = 1'b1;
      tick(); a_clr_status = 1'b0;
   endtask

   task automatic test_read_suppress();
      logic e;
      a_empty = 3'b110;
      for (int k = 1; k <= 62; k++) begin
         a_read_enb[0] = (k == 30);
         tick();
         e = (k == 60);
         n_checks++; if (a_soft_reset[0] !== e) begin n_fail++; $display("FAIL read_suppress k=%0d: got %b expected %b", k, a_soft_reset[0], e); end
      end
      a_read_enb = 3'b000; a_empty = 3'b111;
      tick();
   endtask

   task automatic test_empty_glitch();
      logic e;
      for (int k = 1; k <= 52; k++) begin
         a_empty = (k == 20) ? 3'b111 : 3'b011;
         tick();
         e = (k == 50);
         n_checks++; if (a_soft_reset[2] !== e) begin n_fail++; $display("FAIL empty_glitch k=%0d: got %b expected %b", k, a_soft_reset[2], e); end
      end
   endtask

   task automatic test_clr_priority();
      a_empty = 3'b101;
      for (int k = 1; k <= 30; k++) begin
         a_clr_status = (k == 30);
         tick();
      end
      n_checks++; if (a_soft_reset !== 3'b010 || a_timeout_flag !== 3'b010) begin
         n_fail++; $display("FAIL clr_coincide: got sr=%b flag=%b expected sr=010 flag=010", a_soft_reset, a_timeout_flag); end
      a_empty = 3'b111; a_clr_status = 1'b0;
      tick();
      n_checks++; if (a_timeout_flag !== 3'b010) begin n_fail++; $display("FAIL clr_hold: got %b expected 010", a_timeout_flag); end
      a_clr_status = 1'b1;
      tick(); a_clr_status = 1'b0;
      n_checks++; if (a_timeout_flag !== 3'b000) begin n_fail++; $display("FAIL clr_alone: got %b expected 000", a_timeout_flag); end
   endtask

   task automatic test_config_b();
      logic e;
      b_empty = 5'b11101;
      for (int k = 1; k <= 9; k++) begin
         b_clr_status = (k == 8);
         tick();
         e = (k == 4 || k == 8);
         n_checks++; if (b_soft_reset !== {3'b000, e, 1'b0}) begin n_fail++; $display("FAIL cfgb_pulse k=%0d: got %b expected %b", k, b_soft_reset, {3'b000, e, 1'b0}); end
      end
      n_checks++; if (b_timeout_flag !== 5'b00010) begin n_fail++; $display("FAIL cfgb_flag: got %b expected 00010", b_timeout_flag); end
      b_empty = 5'b11111; b_clr_status = 1'b0;
      b_detect_add = 1'b1; b_data_in = 3'd4; b_write_enb_reg = 1'b1; b_full = 5'b10000;
      tick(); b_detect_add = 1'b0;
      n_checks++; if (b_write_enb !== 5'b10000 || b_fifo_full !== 1'b1 || b_addr_err !== 1'b0) begin
         n_fail++; $display("FAIL cfgb_addr4: got we=%b ff=%b err=%b expected 10000 1 0", b_write_enb, b_fifo_full, b_addr_err); end
      b_detect_add = 1'b1; b_data_in = 3'd5;
      tick(); b_detect_add = 1'b0;
      n_checks++; if (b_write_enb !== 5'b00000 || b_addr_err !== 1'b1) begin
         n_fail++; $display("FAIL cfgb_addr5: got we=%b err=%b expected 00000 1", b_write_enb, b_addr_err); end
   endtask

   task automatic test_random();
      logic [7:0]  ewe;
      logic [13:0] exp_a, act_a;
      logic [21:0] exp_b, act_b;
      for (int n = 0; n < 1500; n++) begin
         resetn = ($urandom_range(0, 299) != 0);
         a_detect_add = ($urandom_range(0, 7) == 0); a_data_in = 2'($urandom);
         a_write_enb_reg = 1'($urandom); a_full = 3'($urandom);
         a_clr_status = ($urandom_range(0, 59) == 0);
         for (int c = 0; c < 3; c++) begin
            a_empty[c] = ($urandom_range(0, 49) == 0);
            a_read_enb[c] = ($urandom_range(0, 39) == 0);
         end
         b_detect_add = ($urandom_range(0, 5) == 0); b_data_in = 3'($urandom);
         b_write_enb_reg = 1'($urandom); b_full = 5'($urandom);
         b_clr_status = ($urandom_range(0, 19) == 0);
         for (int c = 0; c < 5; c++) begin
            b_empty[c] = ($urandom_range(0, 5) == 0);
            b_read_enb[c] = ($urandom_range(0, 4) == 0);
         end
         tick();
         ewe = exp_we(resetn, a_write_enb_reg, ma_addr, 3);
         exp_a = {ewe[2:0], exp_ff(resetn, {5'b00000, a_full}, ma_addr, 3), (ma_addr >= 3), ~a_empty, ma_pulse, ma_flag};
         act_a = {a_write_enb, a_fifo_full, a_addr_err, a_vld_out, a_soft_reset, a_timeout_flag};
         n_checks++; if (act_a !== exp_a) begin n_fail++; $display("FAIL random_a n=%0d: got %b expected %b", n, act_a, exp_a); end
         ewe = exp_we(resetn, b_write_enb_reg, mb_addr, 5);
         exp_b = {ewe[4:0], exp_ff(resetn, {3'b000, b_full}, mb_addr, 5), (mb_addr >= 5), ~b_empty, mb_pulse, mb_flag};
         act_b = {b_write_enb, b_fifo_full, b_addr_err, b_vld_out, b_soft_reset, b_timeout_flag};
         n_checks++; if (act_b !== exp_b) begin n_fail++; $display("FAIL random_b n=%0d: got %b expected %b", n, act_b, exp_b); end
      end
      resetn = 1'b1;
   endtask

   initial begin
      ma_addr = 3; mb_addr = 7;
      ma_pulse = 3'b000; ma_flag = 3'b000; mb_pulse = 5'b00000; mb_flag = 5'b00000;
      for (int c = 0; c < 3; c++) ma_run[c] = 0;
      for (int c = 0; c < 5; c++) mb_run[c] = 0;
      test_reset();
      test_addr_decode();
      test_timeout_periodic();
      test_read_suppress();
      test_empty_glitch();
      test_clr_priority();
      test_config_b();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
